// File: rtl/xy_mode_counter.sv
// Two-switch controlled counter: {X,Y} selects hold/up/down/clear, debounced over two samples.
// Optional XY_SATURATE_EN: clamp at 0/MAX instead of wrapping modulo MAX+1.
module xy_mode_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             X,
  input  logic             Y,
  output logic [WIDTH-1:0] Z,
  output logic             ovf,
  output logic             udf,
  output logic [1:0]       mode
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10,
    CLR  = 2'b11
  } mode_t;

  // One spare bit so Z+STEP and Z+MAX+1 never overflow.
  localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] MOD_W  = MAX_W + 1'b1;

  mode_t            state;
  mode_t            cmd;
  mode_t            pending;
  logic             pending_valid;

  logic [WIDTH:0]   z_ext;
  logic [WIDTH:0]   up_sum;
  logic             up_wrap;
  logic             down_wrap;
  logic [WIDTH-1:0] up_z;
  logic [WIDTH-1:0] down_z;

  assign cmd  = mode_t'({X, Y});
  assign mode = state;

  always_comb begin
    z_ext     = {1'b0, Z};
    up_sum    = z_ext + STEP_W;
    up_wrap   = (up_sum > MAX_W);
    down_wrap = (z_ext < STEP_W);
`ifdef XY_SATURATE_EN
    up_z   = up_wrap   ? WIDTH'(MAX_W) : WIDTH'(up_sum);
    down_z = down_wrap ? '0            : WIDTH'(z_ext - STEP_W);
`else
    up_z   = up_wrap   ? WIDTH'(up_sum - MOD_W)         : WIDTH'(up_sum);
    down_z = down_wrap ? WIDTH'(z_ext + MOD_W - STEP_W) : WIDTH'(z_ext - STEP_W);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      pending       <= IDLE;
      pending_valid <= 1'b0;
      Z             <= '0;
      ovf           <= 1'b0;
      udf           <= 1'b0;
    end else begin
      // A new command must be seen on two consecutive edges before the mode moves.
      if (cmd == state) begin
        pending_valid <= 1'b0;
      end else if (pending_valid && (pending == cmd)) begin
        state         <= cmd;
        pending_valid <= 1'b0;
      end else begin
        pending       <= cmd;
        pending_valid <= 1'b1;
      end

      ovf <= 1'b0;
      udf <= 1'b0;
      // Datapath follows the mode held before this edge.
      unique case (state)
        IDLE: Z <= Z;
        UP: begin
          if (en) begin
            Z   <= up_z;
            ovf <= up_wrap;
          end
        end
        DOWN: begin
          if (en) begin
            Z   <= down_z;
            udf <= down_wrap;
          end
        end
        CLR: Z <= '0;
        default: Z <= Z;
      endcase
    end
  end

endmodule
